sobel_edge_param: RTL and testbench

SOBEL_EDGE_PARAM -- requirements
Module: sobel_edge_param

---
 rtl/sobel_edge_param_if.sv | 23 ++
 rtl/sobel_edge_param.sv | 137 +++++++++++++
 tb/tb_sobel_edge_param.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_param_if.sv
// rtl/sobel_edge_param_if.sv - pixel-in / edge-out stream bundle for sobel_edge_param
interface sobel_edge_param_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic              pix_vld;
  logic [DATA_W-1:0] pix_data;
  logic              frame_start;
  logic              edge_vld;
  logic [OUT_W-1:0]  edge_data;
  logic              edge_1bit;
  logic [DATA_W+2:0] edge_mag;

  modport master (
    output pix_vld, pix_data, frame_start,
    input  edge_vld, edge_data, edge_1bit, edge_mag
  );

  modport slave (
    input  pix_vld, pix_data, frame_start,
    output edge_vld, edge_data, edge_1bit, edge_mag
  );
endinterface

// File: rtl/sobel_edge_param.sv
// rtl/sobel_edge_param.sv - streaming 3x3 Sobel edge detector, L1/L2 threshold, fixed 4-clock latency
module sobel_edge_param #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int OUT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  sobel_edge_param_if.slave bus,
  input  logic [DATA_W+2:0] thr_in,
  input  logic              mode,
  input  logic              invert
);
  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam int SUM_W = DATA_W + 2;
  localparam int MAG_W = DATA_W + 3;
  localparam int SQ_W  = 2 * DATA_W + 6;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic logic [SUM_W-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
    return SUM_W'(a) + {1'b0, b, 1'b0} + SUM_W'(c);
  endfunction

  function automatic logic [SUM_W-1:0] absdiff(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic [MAG_W-1:0] thr_q, cur_thr;
  logic             mode_q, cur_mode;

  // A frame_start pixel overrides the counters and the latched settings for itself.
  always_comb begin
    cur_col  = bus.frame_start ? '0 : col;
    cur_row  = bus.frame_start ? '0 : row;
    cur_thr  = bus.frame_start ? thr_in : thr_q;
    cur_mode = bus.frame_start ? mode : mode_q;
  end

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t win [3][3];

  // lb0 holds line r-1, lb1 line r-2; window column 2 is the newest.
  always_ff @(posedge sys_clk) begin
    if (bus.pix_vld) begin
      lb0[cur_col] <= bus.pix_data;
      lb1[cur_col] <= lb0[cur_col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[cur_col];
      win[1][2] <= lb0[cur_col];
      win[2][2] <= bus.pix_data;
    end
  end

  logic [4:1]       vld, brd, md;
  logic [MAG_W-1:0] thr_p [1:4];
  logic [SUM_W-1:0] gx_p, gx_n, gy_p, gy_n, ax, ay;
  logic [MAG_W-1:0] mag;
  logic [SQ_W-1:0]  sq, thr_sq;
  logic             hit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col    <= '0;
      row    <= '0;
      thr_q  <= '0;
      mode_q <= 1'b0;
      vld    <= '0;
    end else begin
      vld <= {vld[3:1], bus.pix_vld};
      if (bus.pix_vld) begin
        col    <= (cur_col == COL_LAST) ? '0 : cur_col + COL_W'(1);
        if (cur_col == COL_LAST)
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        else
          row <= cur_row;
        thr_q  <= cur_thr;
        mode_q <= cur_mode;
      end
    end
  end

  // Data path free-runs; only the vld tags decide what reaches the output.
  always_ff @(posedge sys_clk) begin
    if (bus.pix_vld) begin
      brd[1]   <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
      md[1]    <= cur_mode;
      thr_p[1] <= cur_thr;
    end
    brd[4:2] <= brd[3:1];
    md[4:2]  <= md[3:1];
    thr_p[2] <= thr_p[1];
    thr_p[3] <= thr_p[2];
    thr_p[4] <= thr_p[3];
    gx_p   <= wsum(win[0][2], win[1][2], win[2][2]);
    gx_n   <= wsum(win[0][0], win[1][0], win[2][0]);
    gy_p   <= wsum(win[0][0], win[0][1], win[0][2]);
    gy_n   <= wsum(win[2][0], win[2][1], win[2][2]);
    ax     <= absdiff(gx_p, gx_n);
    ay     <= absdiff(gy_p, gy_n);
    mag    <= MAG_W'(ax) + MAG_W'(ay);
    sq     <= SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
    thr_sq <= SQ_W'(thr_p[3]) * SQ_W'(thr_p[3]);
  end

  always_comb begin
    hit = 1'b0;
    if (!brd[4])
      hit = md[4] ? (sq >= thr_sq) : (mag >= thr_p[4]);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.edge_vld  <= 1'b0;
      bus.edge_data <= '0;
      bus.edge_1bit <= 1'b0;
      bus.edge_mag  <= '0;
    end else begin
      bus.edge_vld <= vld[4];
      if (vld[4]) begin
        bus.edge_1bit <= hit ^ invert;
        bus.edge_data <= {OUT_W{hit ^ invert}};
        bus.edge_mag  <= brd[4] ? '0 : mag;
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_param.sv
// tb/tb_sobel_edge_param.sv - scoreboard bench for sobel_edge_param on an 8x4 image
module tb_sobel_edge_param;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int OUT_W  = 16;
  localparam int MAG_W  = DATA_W + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [MAG_W-1:0] thr = '0;
  logic             mode = 1'b0;
  logic             invert = 1'b0;

  always #5 clk = ~clk;

  sobel_edge_param_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  sobel_edge_param #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus),
    .thr_in  (thr),
    .mode    (mode),
    .invert  (invert)
  );

  typedef struct {
    int             acc;
    logic [MAG_W-1:0] mag;
    logic           b;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   in_rst = 1'b1;
  logic [OUT_W-1:0] last_data = '0;
  logic             last_b = 1'b0;
  logic [MAG_W-1:0] last_mag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per edge_vld, otherwise checks outputs hold.
  always @(negedge clk) begin
    if (bus.edge_vld) begin
      if (q.size() == 0) begin
        check("unexpected_edge_vld", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("latency", cyc - mon_e.acc, 4);
        check("edge_mag", bus.edge_mag, mon_e.mag);
        check("edge_1bit", bus.edge_1bit, mon_e.b);
        check("edge_data", bus.edge_data, {OUT_W{mon_e.b}});
      end
      last_data = bus.edge_data;
      last_b    = bus.edge_1bit;
      last_mag  = bus.edge_mag;
    end else if (in_rst) begin
      last_data = '0;
      last_b    = 1'b0;
      last_mag  = '0;
    end else begin
      check("hold", {bus.edge_data, bus.edge_1bit, bus.edge_mag}, {last_data, last_b, last_mag});
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_vld"},  bus.edge_vld, 0);
    check({tag, "_data"}, bus.edge_data, 0);
    check({tag, "_1bit"}, bus.edge_1bit, 0);
    check({tag, "_mag"},  bus.edge_mag, 0);
  endtask

  // step=0: flat 100; step=1: 0 for col<4, 255 for col>=4.
  // Expected |Gx|+|Gy| is 1020 at accepted rows >=2, cols 4 and 5, else 0.
  task automatic drive_frame(input bit step, input int thr_v, input bit md, input bit inv,
                             input bit edges, input bit gaps, input int npix,
                             input int thr_mid, input bit drain);
    exp_t ed;
    for (int i = 0; i < npix; i++) begin
      int r = i / IMG_W;
      int c = i % IMG_W;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.pix_vld = 1'b0;
          bus.frame_start = 1'b0;
        end
      end
      @(negedge clk);
      bus.pix_vld     = 1'b1;
      bus.frame_start = (i == 0);
      bus.pix_data    = step ? ((c >= 4) ? 8'd255 : 8'd0) : 8'd100;
      if (i == 0) begin
        thr    = MAG_W'(thr_v);
        mode   = md;
        invert = inv;
      end
      if (i == 10 && thr_mid >= 0) thr = MAG_W'(thr_mid);
      ed.acc = cyc + 1;
      ed.mag = (step && r >= 2 && (c == 4 || c == 5)) ? MAG_W'(1020) : '0;
      ed.b   = ((ed.mag != 0) && edges) ^ inv;
      q.push_back(ed);
    end
    @(negedge clk);
    bus.pix_vld     = 1'b0;
    bus.frame_start = 1'b0;
    if (drain) repeat (6) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_rst = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    check_zero("after_reset");
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
  endtask

  initial begin
    bus.pix_vld     = 1'b0;
    bus.pix_data    = '0;
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;

    drive_frame(1'b0,   10, 1'b0, 1'b0, 1'b1, 1'b0, 32,   -1, 1'b1); // flat
    drive_frame(1'b1,  100, 1'b0, 1'b0, 1'b1, 1'b0, 32,   -1, 1'b1); // step L1
    drive_frame(1'b1, 1020, 1'b1, 1'b0, 1'b1, 1'b0, 32,   -1, 1'b1); // L2 equality
    drive_frame(1'b1, 1021, 1'b1, 1'b0, 1'b0, 1'b0, 32,   -1, 1'b1); // L2 just above
    drive_frame(1'b1, 1020, 1'b1, 1'b1, 1'b1, 1'b0, 32,   -1, 1'b1); // inverted
    drive_frame(1'b1,  100, 1'b0, 1'b0, 1'b1, 1'b1, 32,   -1, 1'b1); // gapped
    drive_frame(1'b1,  100, 1'b0, 1'b0, 1'b1, 1'b0, 32, 2000, 1'b1); // mid-frame thr change
    drive_frame(1'b1, 2000, 1'b0, 1'b0, 1'b0, 1'b0, 32,   -1, 1'b1); // new thr takes effect
    drive_frame(1'b1,  100, 1'b0, 1'b0, 1'b1, 1'b0, 21,   -1, 1'b0); // aborted by reset
    pulse_reset();
    drive_frame(1'b1,  100, 1'b0, 1'b0, 1'b1, 1'b0, 32,   -1, 1'b1); // clean frame after reset

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    check("drain_pending", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
